dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port 0: CPU load/store path
  - port 1: DMA/debug loader
- Sits directly in front of the data memory and drives its address, write_data, MemWrite and MemRead inputs.
- Arbitration is round-robin with bounded burst tenure, so neither port can starve the other.
- Read data is captured from the memory's combinational read output and returned one cycle after the accepted beat.

Parameters:
- AW, 8, memory word-address width (256 words)
- DW, 32, data width
- MAX_BURST, 4, maximum consecutive beats granted to one port while the other is requesting (range 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- req0  in  1  port 0 request; level, held until ack0
- we0  in  1  port 0 write (1) / read (0)
- addr0  in  AW  port 0 word address
- wdata0  in  DW  port 0 write data
- ack0  out  1  port 0 beat accepted this cycle (combinational)
- rvalid0  out  1  port 0 read data valid (registered)
- rdata0  out  DW  port 0 read data (registered)
- req1/we1/addr1/wdata1/ack1/rvalid1/rdata1: same widths and meanings for port 1
- mem_addr  out  32  to memory address, zero-extended from AW
- mem_wdata  out  DW  to memory write_data
- mem_we  out  1  to memory MemWrite
- mem_re  out  1  to memory MemRead
- mem_rdata  in  DW  from memory read_data (combinational)
- owner  out  1  port currently holding the grant (debug)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, owner=0, last=1 (so port 0 wins the first tie)
  - burst count=0
  - all ack/rvalid/mem_we/mem_re=0; rdata0/rdata1=0
- States:
  - IDLE: no request.
  - OWN: grant held by `owner`.
- IDLE transitions:
  - One request: grant that port in the same cycle. ack is asserted in that cycle and state moves to OWN next cycle.
  - Both requesting: grant the port != last.
- OWN, owner still requesting and either (other idle) or (count < MAX_BURST): keep grant, ack=1, count++.
  - count saturates at MAX_BURST when the other port is idle.
- OWN, owner still requesting, count == MAX_BURST and other requesting: hand over.
  - This cycle serves the other port (ack_other=1).
  - owner toggles, count=1, last=old owner.
- OWN, owner drops req:
  - Other requesting: grant it the same cycle, with count=1.
  - Otherwise: go to IDLE and set last=owner.
- Exactly one ack per cycle at most; a beat occurs iff ack=1. Zero-bubble handover.
- Memory drive:
  - mem_we = ack & we_sel; mem_re = ack & ~we_sel.
  - mem_addr/mem_wdata come from the selected port's inputs; they are 0 when no ack.
- Reads:
  - On a read beat, mem_rdata is registered into rdata_sel and rvalid_sel=1 in the next cycle, for exactly one cycle.
  - rdata holds its value until the next read for that port.
- Writes:
  - Complete at the clk edge of the ack cycle.
  - Read-after-write to the same address on the next beat returns the new data.
- Requester rule: a requester must not change we/addr/wdata while req=1 and ack=0. The bench checks this; the RTL does not.
- rst asserted mid-burst: the beat is aborted and any pending rvalid is cleared. A write on that edge is not guaranteed.

Optional Feature:
- DMEM_ARB_STATS_EN: adds outputs stall0, stall1 (16 bits each).
  - Each counts cycles its port had req=1 and ack=0.
  - Counters saturate at 0xFFFF and are cleared by rst.
- Without the macro: the ports are absent and no counter logic is built.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, OWN)
  - the port index constants (PORT_CPU=0, PORT_DMA=1)
  - the default AW, DW and MAX_BURST
- Sub-module rr_grant: combinational next-owner decision from (req0, req1, owner, last, count, state). Instantiated once.
- The top module holds the state/owner/last/count registers, the memory mux and the read-return registers.

Test Plan:
- Reset then single requester: req0 write addr 5 = 0x1234, then read addr 5.
  - Expected: ack0 in each request cycle; rvalid0 one cycle after the read ack with rdata0=0x1234; port 1 signals stay 0.
- Simultaneous first request: req0 and req1 both rise in the same cycle after reset.
  - Expected: port 0 acked first.
- Both ports continuously requesting reads, MAX_BURST=4.
  - Expected: ack pattern 0,0,0,0,1,1,1,1,0,... with no idle cycles; each rvalid follows its ack by exactly one cycle.
- Port 0 streaming while port 1 is idle for 10 cycles.
  - Expected: 10 consecutive ack0. Port 1 then requests and is acked within 1 cycle, since the saturated count forces handover.
- Port 1 writes addr 2 = 0xDEAD; port 0 reads addr 2 on the next beat.
  - Expected: rdata0=0xDEAD.
- rst pulsed mid-burst with a read pending.
  - Expected: rvalid0/1=0 and ack=0 immediately (asynchronous); after release, port 0 wins the next tie.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port indices, defaults.
package dmem_arbiter_pkg;

  localparam int unsigned STATE_W = 1;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  localparam int unsigned AW_DEF        = 8;
  localparam int unsigned DW_DEF        = 32;
  localparam int unsigned MAX_BURST_DEF = 4;
  localparam int unsigned CNT_W         = 4;

endpackage

// File: rtl/dmem_arbiter_rr_grant.sv
// Combinational round-robin grant with bounded burst tenure; computes this cycle's
// grant and the next owner/last/count/state values.
module dmem_arbiter_rr_grant
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic               req0_i,
  input  logic               req1_i,
  input  logic [STATE_W-1:0] state_i,
  input  logic               owner_i,
  input  logic               last_i,
  input  logic [CNT_W-1:0]   count_i,
  output logic               gnt_vld_o,
  output logic               gnt_port_o,
  output logic [STATE_W-1:0] state_d_o,
  output logic               owner_d_o,
  output logic               last_d_o,
  output logic [CNT_W-1:0]   count_d_o
);

  logic req_own;
  logic req_oth;
  logic below_max;

  assign req_own   = owner_i ? req1_i : req0_i;
  assign req_oth   = owner_i ? req0_i : req1_i;
  assign below_max = (count_i < CNT_W'(MAX_BURST));

  always_comb begin
    gnt_vld_o  = 1'b0;
    gnt_port_o = owner_i;
    state_d_o  = state_i;
    owner_d_o  = owner_i;
    last_d_o   = last_i;
    count_d_o  = count_i;
    if (state_i == ST_IDLE) begin
      if (req0_i || req1_i) begin
        // Tie goes to the port that was not served last.
        gnt_vld_o  = 1'b1;
        gnt_port_o = (req0_i && req1_i) ? ~last_i : req1_i;
        owner_d_o  = gnt_port_o;
        state_d_o  = ST_OWN;
        count_d_o  = CNT_W'(1);
      end
    end else begin
      if (req_own && (!req_oth || below_max)) begin
        gnt_vld_o  = 1'b1;
        gnt_port_o = owner_i;
        if (below_max) begin
          count_d_o = count_i + CNT_W'(1);
        end
      end else if (req_oth) begin
        // Zero-bubble handover: the other port is served in this same cycle.
        gnt_vld_o  = 1'b1;
        gnt_port_o = ~owner_i;
        owner_d_o  = ~owner_i;
        last_d_o   = owner_i;
        count_d_o  = CNT_W'(1);
      end else begin
        state_d_o = ST_IDLE;
        last_d_o  = owner_i;
        count_d_o = '0;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port data memory.
// Optional stall counters enabled with `define DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned AW        = AW_DEF,
  parameter int unsigned DW        = DW_DEF,
  parameter int unsigned MAX_BURST = MAX_BURST_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          ack0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          ack1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic [31:0]   mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  output logic          mem_re,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stall0,
  output logic [15:0]   stall1
`endif
);

  logic [STATE_W-1:0] state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               gnt_vld;
  logic               gnt_port;
  logic               beat_c;
  logic               we_sel;
  logic [AW-1:0]      addr_sel;
  logic [DW-1:0]      wdata_sel;
  logic               rvalid0_q, rvalid1_q;
  logic [DW-1:0]      rdata0_q, rdata1_q;

  dmem_arbiter_rr_grant #(
    .MAX_BURST (MAX_BURST)
  ) u_rr_grant (
    .req0_i     (req0),
    .req1_i     (req1),
    .state_i    (state_q),
    .owner_i    (owner_q),
    .last_i     (last_q),
    .count_i    (count_q),
    .gnt_vld_o  (gnt_vld),
    .gnt_port_o (gnt_port),
    .state_d_o  (state_d),
    .owner_d_o  (owner_d),
    .last_d_o   (last_d),
    .count_d_o  (count_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= PORT_CPU;
      last_q  <= PORT_DMA;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  // Reset kills the beat immediately, not just at the next edge.
  assign beat_c = gnt_vld & ~rst;
  assign ack0   = beat_c & (gnt_port == PORT_CPU);
  assign ack1   = beat_c & (gnt_port == PORT_DMA);

  assign we_sel    = (gnt_port == PORT_DMA) ? we1    : we0;
  assign addr_sel  = (gnt_port == PORT_DMA) ? addr1  : addr0;
  assign wdata_sel = (gnt_port == PORT_DMA) ? wdata1 : wdata0;

  assign mem_we    = beat_c & we_sel;
  assign mem_re    = beat_c & ~we_sel;
  assign mem_addr  = beat_c ? 32'(addr_sel) : 32'd0;
  assign mem_wdata = beat_c ? wdata_sel : '0;

  // Read return: capture combinational memory data on the read beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= ack0 & ~we0;
      rvalid1_q <= ack1 & ~we1;
      if (ack0 && !we0) begin
        rdata0_q <= mem_rdata;
      end
      if (ack1 && !we1) begin
        rdata1_q <= mem_rdata;
      end
    end
  end

  assign rvalid0 = rvalid0_q;
  assign rvalid1 = rvalid1_q;
  assign rdata0  = rdata0_q;
  assign rdata1  = rdata1_q;
  assign owner   = owner_q;

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stall0_q, stall1_q;

  // Saturating count of cycles each port waited with a request pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (req0 && !ack0 && (stall0_q != 16'hFFFF)) begin
        stall0_q <= stall0_q + 16'd1;
      end
      if (req1 && !ack1 && (stall1_q != 16'hFFFF)) begin
        stall1_q <= stall1_q + 16'd1;
      end
    end
  end

  assign stall0 = stall0_q;
  assign stall1 = stall1_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a read-data scoreboard
// and a simple behavioural memory behind the arbiter.
module tb_dmem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          req0, we0, req1, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic [31:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_re;
  logic          owner;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stall0, stall1;
`endif

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .ack0      (ack0),
    .rvalid0   (rvalid0),
    .rdata0    (rdata0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack1      (ack1),
    .rvalid1   (rvalid1),
    .rdata1    (rdata1),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .owner     (owner)
`ifdef DMEM_ARB_STATS_EN
    ,
    .stall0    (stall0),
    .stall1    (stall1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, write on the clock edge.
  logic [DW-1:0] tb_mem [256];
  bit            mem_loaded;
  assign mem_rdata = tb_mem[mem_addr[7:0]];
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) tb_mem[i] <= 32'hA500_0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (mem_we) begin
      tb_mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  typedef struct {
    int            cyc;
    logic          port;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  logic [DW-1:0] ref_mem [256];
  int            checks;
  int            errors;
  int            cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic step(input logic e0, input logic e1);
    sb_t           ent;
    logic          exp_rv0, exp_rv1, pwe;
    logic [DW-1:0] exp_rd0, exp_rd1, pdata;
    logic [AW-1:0] paddr;
    exp_rv0 = 1'b0; exp_rv1 = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    #3;
    if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
      ent = sb.pop_front();
      if (ent.port) begin exp_rv1 = 1'b1; exp_rd1 = ent.data; end
      else          begin exp_rv0 = 1'b1; exp_rd0 = ent.data; end
    end
    chk("rvalid0", 32'(rvalid0), 32'(exp_rv0));
    chk("rvalid1", 32'(rvalid1), 32'(exp_rv1));
    if (exp_rv0) chk("rdata0", rdata0, exp_rd0);
    if (exp_rv1) chk("rdata1", rdata1, exp_rd1);
    chk("ack0", 32'(ack0), 32'(e0));
    chk("ack1", 32'(ack1), 32'(e1));
    if (e0 || e1) begin
      pwe   = e1 ? we1 : we0;
      paddr = e1 ? addr1 : addr0;
      pdata = e1 ? wdata1 : wdata0;
      chk("mem_addr", mem_addr, 32'(paddr));
      chk("mem_we", 32'(mem_we), 32'(pwe));
      chk("mem_re", 32'(mem_re), 32'(!pwe));
      if (pwe) begin
        chk("mem_wdata", mem_wdata, pdata);
        ref_mem[paddr] = pdata;
      end else begin
        sb.push_back('{cyc: cyc, port: e1, data: ref_mem[paddr]});
      end
    end else begin
      chk("mem_idle", 32'({mem_we, mem_re}), 32'd0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'({ack0, ack1}), 32'd0);
    chk("rst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata1", rdata1, 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    rst = 1'b0;

    // Simultaneous first request, both streaming reads: 4-beat tenures.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd10;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd20;
    for (int i = 0; i < 10; i++) begin
      step(((i / 4) % 2) == 0, ((i / 4) % 2) == 1);
    end
`ifdef DMEM_ARB_STATS_EN
    chk("stall0", 32'(stall0), 32'd4);
    chk("stall1", 32'(stall1), 32'd6);
`endif
    req0 = 1'b0; req1 = 1'b0;
    step(1'b0, 1'b0);

    // Single requester write then read-back.
    do_reset();
    req0 = 1'b1; we0 = 1'b1; addr0 = 8'd5; wdata0 = 32'h0000_1234;
    step(1'b1, 1'b0);
    we0 = 1'b0;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);
    chk("rdata0_hold", rdata0, 32'h0000_1234);
    chk("rdata1_quiet", rdata1, 32'd0);

    // Port 0 streams alone, then port 1 gets in immediately on saturation.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd7;
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd8;
    step(1'b0, 1'b1);
    chk("owner_handover", 32'(owner), 32'd1);
    req1 = 1'b0;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);

    // Port 1 write followed by port 0 read of the same word on the next beat.
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'd2; wdata1 = 32'h0000_DEAD;
    step(1'b0, 1'b1);
    req1 = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd2;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b0);
    chk("raw_rdata0", rdata0, 32'h0000_DEAD);

    // Reset asserted with a read return pending.
    req0 = 1'b1; we0 = 1'b0; addr0 = 8'd5;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst = 1'b1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 8'd9;
    #1;
    chk("midrst_ack", 32'({ack0, ack1}), 32'd0);
    chk("midrst_rvalid", 32'({rvalid0, rvalid1}), 32'd0);
    chk("midrst_mem", 32'({mem_we, mem_re}), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0);
    req0 = 1'b0;
    step(1'b0, 1'b1);
    req1 = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
